shift_seq_ctrl: RTL and testbench
=================================

# shift_seq_ctrl

Sequencer for the WIDTH-bit LED shift register datapath. It loads a start pattern, then applies a programmed number of shift or rotate steps at a programmable rate with a start/busy/done handshake. The block owns the shift register and the step-rate prescaler. It sits between the board-level control inputs (keys and switches) and the LEDR outputs.

## Interface
- WIDTH, 10: shift register width.
- CNT_W, 8: width of the step count.
- DIV_W, 24: width of the prescaler period.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a run. Sampled only in IDLE.
- stop  in  1  abort a run. Sampled only in RUN.
- mode  in  2  shift mode: 00 shift-left with ser_in fill, 01 rotate-left, 10 rotate-right, 11 bounce.
- load_data  in  WIDTH  initial pattern.
- steps  in  CNT_W  number of shifts. 0 means free-run until stop.
- period  in  DIV_W  clk cycles between shifts. 0 is treated as 1.
- ser_in  in  1  fill bit for mode 00, sampled at each shift.
- q  out  WIDTH  shift register contents.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at end of a run.
- step_tick  out  1  high in each cycle in which a shift is applied.

## Operation
- Reset values: state IDLE, q=0, busy=0, done=0, step_tick=0, dir=LEFT, prescaler=0, step counter=0.
- States and transitions:
  - IDLE:
    - start=1 → RUN at the next edge.
    - On that same edge: q←load_data; mode, steps and period latched; prescaler←0; remaining←steps; dir←LEFT.
    - Otherwise q holds.
  - RUN:
    - The prescaler counts 0..P-1, where P=max(period,1).
    - tick = (prescaler==P-1). On tick the prescaler wraps to 0.
    - On tick with stop=0: apply one shift, assert step_tick, and decrement remaining if the latched steps≠0.
    - If this shift makes remaining reach 0 (latched steps≠0), go to DONE.
    - stop=1 → DONE at the next edge. No shift occurs, even if tick coincides. stop outranks tick.
  - DONE: done=1 for exactly one cycle, busy=1, q holds. Then → IDLE.
- Shift rules:
  - 00: q←{q[W-2:0], ser_in}.
  - 01: q←{q[W-2:0], q[W-1]}.
  - 10: q←{q[0], q[W-1:1]}.
  - 11 (bounce, zero fill):
    - dir=LEFT and q[W-1]=1: dir←RIGHT, shift right.
    - dir=RIGHT and q[0]=1: dir←LEFT, shift left.
    - Otherwise shift in dir.
    - q=0 stays 0.
- start during busy is ignored; it is not queued.
- Input changes during RUN have no effect, because all settings are latched. ser_in and stop are the exceptions.
- Asynchronous rst mid-run forces the reset values immediately. There is no done pulse.

## Timing
- start sampled at edge N: q=load_data and busy=1 after edge N.
- First shift at edge N+P.
- Shift k (k=1..S, where S is the latched steps value) occurs at edge N+k·P. step_tick is high in the cycle before that edge.
- After the final shift (edge N+S·P), done is high for one cycle and busy stays 1. busy=0 and the state is IDLE after edge N+S·P+1.
- Run latency from start to done rising: S·P cycles.
- stop sampled at edge M: done is high after M, IDLE after M+1.
- Back-to-back: start is accepted in the first IDLE cycle after DONE.
- Prescaler width is DIV_W. The step counter is CNT_W with no wrap, because decrement is gated at 0.

## Structure
- Package shift_seq_pkg:
  - state encoding (IDLE, RUN, DONE)
  - mode constants (MODE_SHL_FILL, MODE_ROL, MODE_ROR, MODE_BOUNCE)
  - direction constants
- Sub-module rate_prescaler:
  - inputs: clk, rst, clear, enable, period.
  - output: tick.
  - period 0 is treated as 1.
- FSM, step counter and shift register live in shift_seq_ctrl.

## Test plan
- Reset mid-run: assert rst while RUN with q=10'h0F0 → q=0, busy=0, done=0 immediately; no done pulse after release.
- Rotate-left count: mode=01, load_data=10'h001, steps=3, period=4, start at edge 0 →
  - q=001 after edge 0, 002 after edge 4, 004 after edge 8, 008 after edge 12;
  - done pulse after edge 12; busy=0 after edge 13.
- Fill mode with period=0: mode=00, load_data=0, ser_in=1, steps=10 → a shift every cycle; q=10'h3FF after 10 shifts; done one cycle later.
- Bounce: mode=11, load_data=10'h100, period=1, free-run →
  - q sequence 100, 200, 100, 080, …, 001, 002;
  - stop issued after the 2 following the 001 → done, q holds 002.
- Stop/tick collision and ignored start: mode=10, load_data=10'h200, period=2, steps=0 →
  - stop asserted on a tick cycle gives no shift, q holds, done next cycle;
  - start pulsed while busy has no effect on q or on the latched settings.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types for the LED shift sequencer: FSM states, shift modes and bounce direction.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_SHL_FILL = 2'b00,
    MODE_ROL      = 2'b01,
    MODE_ROR      = 2'b10,
    MODE_BOUNCE   = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/shift_seq_ctrl_prescaler.sv
// Step-rate prescaler: counts 0..P-1 while enabled and flags the last count, P = max(period,1).
module rate_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic [DIV_W-1:0] last_cnt;

  // A zero period collapses to a tick every enabled cycle.
  assign last_cnt = (period == '0) ? '0 : period - DIV_W'(1);
  assign tick     = enable && (cnt_q == last_cnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// LED shift sequencer: loads a pattern, then applies a counted or free-running series of
// shift/rotate/bounce steps at the prescaled rate with a start/busy/done handshake.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int CNT_W = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] steps,
  input  logic [DIV_W-1:0] period,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             step_tick,
  output state_t           state_dbg
);

  // Handshake: start is only looked at in IDLE and stop only in RUN; busy covers RUN and
  // DONE, done is a single-cycle pulse in DONE, and start while busy is dropped, not queued.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  mode_t            mode_q;
  logic [CNT_W-1:0] steps_q;
  logic [DIV_W-1:0] period_q;

  logic             latch_en;
  logic             presc_clear;
  logic             presc_en;
  logic             tick;
  logic [WIDTH-1:0] shift_val;
  dir_t             dir_next;

  assign presc_en = (state_q == ST_RUN);

  rate_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (presc_clear),
    .enable (presc_en),
    .period (period_q),
    .tick   (tick)
  );

  // Candidate next pattern for the latched mode; only committed on an applied step.
  always_comb begin
    shift_val = q_q;
    dir_next  = dir_q;
    case (mode_q)
      MODE_SHL_FILL: shift_val = {q_q[WIDTH-2:0], ser_in};
      MODE_ROL:      shift_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
      MODE_ROR:      shift_val = {q_q[0], q_q[WIDTH-1:1]};
      default: begin
        if (dir_q == DIR_LEFT && q_q[WIDTH-1]) begin
          dir_next  = DIR_RIGHT;
          shift_val = {1'b0, q_q[WIDTH-1:1]};
        end else if (dir_q == DIR_RIGHT && q_q[0]) begin
          dir_next  = DIR_LEFT;
          shift_val = {q_q[WIDTH-2:0], 1'b0};
        end else if (dir_q == DIR_LEFT) begin
          shift_val = {q_q[WIDTH-2:0], 1'b0};
        end else begin
          shift_val = {1'b0, q_q[WIDTH-1:1]};
        end
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    q_d         = q_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    latch_en    = 1'b0;
    presc_clear = 1'b0;
    step_tick   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          q_d         = load_data;
          dir_d       = DIR_LEFT;
          remaining_d = steps;
          presc_clear = 1'b1;
          latch_en    = 1'b1;
        end
      end
      ST_RUN: begin
        // stop wins over a coinciding tick: the run ends without a final shift.
        if (stop) begin
          state_d = ST_DONE;
        end else if (tick) begin
          step_tick = 1'b1;
          q_d       = shift_val;
          dir_d     = dir_next;
          if (steps_q != '0 && remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      q_q         <= '0;
      dir_q       <= DIR_LEFT;
      remaining_q <= '0;
      mode_q      <= MODE_SHL_FILL;
      steps_q     <= '0;
      period_q    <= '0;
    end else begin
      state_q     <= state_d;
      q_q         <= q_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      if (latch_en) begin
        mode_q   <= mode_t'(mode);
        steps_q  <= steps;
        period_q <= period;
      end
    end
  end

  assign q         = q_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: run-level vector table plus hand-written multi-cycle sequences.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int WIDTH = 10;
  localparam int CNT_W = 8;
  localparam int DIV_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic [1:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic [CNT_W-1:0] steps;
  logic [DIV_W-1:0] period;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             step_tick;
  state_t           state_dbg;

  int tests = 0;
  int fails = 0;
  logic [WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] load;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] period;
    logic             ser;
    logic [WIDTH-1:0] exp_q;
    int               exp_lat;
  } vec_t;

  vec_t vecs[7];

  shift_seq_ctrl #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .load_data (load_data),
    .steps     (steps),
    .period    (period),
    .ser_in    (ser_in),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .step_tick (step_tick),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_run(input logic [1:0] m, input logic [WIDTH-1:0] ld,
                           input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] p,
                           input logic ser);
    mode      = m;
    load_data = ld;
    steps     = s;
    period    = p;
    ser_in    = ser;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic run_vector(input int idx);
    int lat;
    int ticks;
    lat   = 0;
    ticks = 0;
    start_run(vecs[idx].mode, vecs[idx].load, vecs[idx].steps, vecs[idx].period, vecs[idx].ser);
    while (!done && lat < 2000) begin
      if (step_tick) ticks++;
      step();
      lat++;
    end
    check($sformatf("vec%0d latency", idx), lat, vecs[idx].exp_lat);
    check($sformatf("vec%0d final q", idx), q, vecs[idx].exp_q);
    check($sformatf("vec%0d step count", idx), ticks, int'(vecs[idx].steps));
    check($sformatf("vec%0d busy in done", idx), busy, 1);
    step();
    check($sformatf("vec%0d busy after", idx), busy, 0);
    check($sformatf("vec%0d done after", idx), done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{MODE_ROL,      10'h001, 8'd3,  24'd4, 1'b0, 10'h008, 12};
    vecs[1] = '{MODE_SHL_FILL, 10'h000, 8'd10, 24'd0, 1'b1, 10'h3FF, 10};
    vecs[2] = '{MODE_ROR,      10'h001, 8'd2,  24'd3, 1'b0, 10'h100, 6};
    vecs[3] = '{MODE_SHL_FILL, 10'h3FF, 8'd4,  24'd1, 1'b0, 10'h3F0, 4};
    vecs[4] = '{MODE_BOUNCE,   10'h100, 8'd3,  24'd2, 1'b0, 10'h080, 6};
    vecs[5] = '{MODE_ROL,      10'h2AA, 8'd1,  24'd5, 1'b0, 10'h155, 5};
    vecs[6] = '{MODE_BOUNCE,   10'h000, 8'd2,  24'd1, 1'b0, 10'h000, 2};

    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00;
    load_data = '0; steps = '0; period = '0; ser_in = 1'b0;
    repeat (2) step();
    check("reset q", q, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset step_tick", step_tick, 0);
    rst = 1'b0;
    step();

    // Async reset in the middle of a run.
    start_run(MODE_ROL, 10'h0F0, 8'd0, 24'd100, 1'b0);
    repeat (5) step();
    check("midrun q", q, 10'h0F0);
    check("midrun busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async rst q", q, 0);
    check("async rst busy", busy, 0);
    check("async rst done", done, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post rst no done", done, 0);
      check("post rst idle", busy, 0);
    end

    // Rotate-left edge by edge: start at edge 0, shifts at 4, 8, 12.
    start_run(MODE_ROL, 10'h001, 8'd3, 24'd4, 1'b0);
    check("rol e0 q", q, 10'h001);
    check("rol e0 busy", busy, 1);
    check("rol e0 done", done, 0);
    for (int e = 1; e <= 13; e++) begin
      step();
      check($sformatf("rol e%0d q", e), q, 32'h1 << (e / 4));
      check($sformatf("rol e%0d busy", e), busy, (e <= 12) ? 1 : 0);
      check($sformatf("rol e%0d done", e), done, (e == 12) ? 1 : 0);
      check($sformatf("rol e%0d tick", e), step_tick, ((e % 4 == 3) && (e < 12)) ? 1 : 0);
    end

    // Table of complete runs, each started in the first IDLE cycle after the previous DONE.
    for (int i = 0; i < 7; i++) run_vector(i);

    // Bounce free-run, stop landing on a tick cycle once back at 002.
    start_run(MODE_BOUNCE, 10'h100, 8'd0, 24'd1, 1'b0);
    check("bounce load", q, 10'h100);
    exp_q = '{10'h200, 10'h100, 10'h080, 10'h040, 10'h020, 10'h010,
              10'h008, 10'h004, 10'h002, 10'h001, 10'h002};
    while (exp_q.size() > 0) begin
      step();
      check("bounce q", q, exp_q.pop_front());
    end
    stop = 1'b1;
    #1;
    check("bounce stop masks tick", step_tick, 0);
    step();
    stop = 1'b0;
    check("bounce done", done, 1);
    check("bounce q held", q, 10'h002);
    step();
    check("bounce idle", busy, 0);
    check("bounce q final", q, 10'h002);

    // Stop/tick collision plus a start pulse while busy.
    start_run(MODE_ROR, 10'h200, 8'd0, 24'd2, 1'b0);
    check("coll load", q, 10'h200);
    step();
    check("coll first tick", step_tick, 1);
    start = 1'b1; load_data = 10'h3FF; mode = MODE_SHL_FILL; period = 24'd7; steps = 8'd1;
    step();
    start = 1'b0;
    check("coll q after shift", q, 10'h100);
    check("coll busy", busy, 1);
    step();
    check("coll latched period", step_tick, 1);
    check("coll still running", busy, 1);
    stop = 1'b1;
    #1;
    check("coll stop masks tick", step_tick, 0);
    step();
    stop = 1'b0;
    check("coll done", done, 1);
    check("coll q hold", q, 10'h100);
    step();
    check("coll idle", busy, 0);
    check("coll q final", q, 10'h100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
